// File: rtl/pingpong_pkg.sv
// Shared definitions for the ECG ping-pong frame controller and its benches.
package pingpong_pkg;

    // Default widths matching the switching_block memory ports.
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    // Bank select values on the switching_block select line.
    localparam logic BANK_M1 = 1'b0;
    localparam logic BANK_M2 = 1'b1;

    // Frame controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2,
        SWAP = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] cnt_r;

    // Count increments, stop at the maximum, clear has priority.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != MAX_VAL)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign q = cnt_r;

endmodule

// File: rtl/pingpong_frame_ctrl.sv
// Ping-pong frame controller: fills the current write bank with ADC samples,
// hands full banks to the reader via switch/frame_ready and counts samples
// dropped while the reader still holds the other bank.
module pingpong_frame_ctrl
    import pingpong_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAME_LEN = 4096,
    parameter int OVR_W     = 16
) (
    input  logic              lc_clk_c,
    input  logic              rst,
    input  logic              enable,
    input  logic              samp_valid,
    input  logic [DATA_W-1:0] samp_data,
    input  logic              rd_done,
    output logic              switch,
    output logic [ADDR_W-1:0] lc_addra,
    output logic              wr_en,
    output logic [DATA_W-1:0] dt_an,
    output logic              frame_ready,
    output logic              rd_busy,
    output logic [OVR_W-1:0]  overrun_cnt,
    output logic [1:0]        state_o
);

    // Address of the last sample of a frame.
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_LEN - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] wr_ptr_nxt_s;
    logic              accept_s;
    logic              drop_s;
    logic              swap_s;

    logic              switch_r;
    logic [ADDR_W-1:0] lc_addra_r;
    logic              wr_en_r;
    logic [DATA_W-1:0] dt_an_r;
    logic              frame_ready_r;
    logic              rd_busy_r;

    // Next-state, write-pointer and event decode.
    always_comb begin
        state_nxt_s  = state_r;
        wr_ptr_nxt_s = wr_ptr_r;
        accept_s     = 1'b0;
        drop_s       = 1'b0;
        swap_s       = 1'b0;
        case (state_r)
            IDLE: begin
                wr_ptr_nxt_s = {ADDR_W{1'b0}};
                if (enable) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                // A sample arriving in the abort cycle is still written.
                accept_s = samp_valid;
                if (!enable) begin
                    state_nxt_s  = IDLE;
                    wr_ptr_nxt_s = {ADDR_W{1'b0}};
                end else if (samp_valid && (wr_ptr_r == LAST_PTR)) begin
                    state_nxt_s  = FULL;
                    wr_ptr_nxt_s = {ADDR_W{1'b0}};
                end else if (samp_valid) begin
                    wr_ptr_nxt_s = wr_ptr_r + ADDR_W'(1);
                end else begin
                    wr_ptr_nxt_s = wr_ptr_r;
                end
            end
            FULL: begin
                drop_s = samp_valid;
                if (!enable) begin
                    state_nxt_s  = IDLE;
                    wr_ptr_nxt_s = {ADDR_W{1'b0}};
                end else if (!rd_busy_r || rd_done) begin
                    state_nxt_s = SWAP;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            SWAP: begin
                // The swap always completes, even when enable drops here.
                drop_s = samp_valid;
                swap_s = 1'b1;
                if (enable) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                wr_ptr_nxt_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State and write-pointer registers.
    always_ff @(posedge lc_clk_c) begin
        if (rst) begin
            state_r  <= IDLE;
            wr_ptr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
        end
    end

    // Registered write port, bank select and reader handshake outputs.
    always_ff @(posedge lc_clk_c) begin
        if (rst) begin
            switch_r      <= BANK_M1;
            lc_addra_r    <= {ADDR_W{1'b0}};
            wr_en_r       <= 1'b0;
            dt_an_r       <= {DATA_W{1'b0}};
            frame_ready_r <= 1'b0;
            rd_busy_r     <= 1'b0;
        end else begin
            wr_en_r       <= accept_s;
            frame_ready_r <= swap_s;
            if (accept_s) begin
                lc_addra_r <= wr_ptr_r;
                dt_an_r    <= samp_data;
            end else begin
                lc_addra_r <= lc_addra_r;
                dt_an_r    <= dt_an_r;
            end
            if (swap_s) begin
                switch_r <= ~switch_r;
            end else begin
                switch_r <= switch_r;
            end
            // Handing over a bank wins over a same-cycle release.
            if (swap_s) begin
                rd_busy_r <= 1'b1;
            end else if (rd_done) begin
                rd_busy_r <= 1'b0;
            end else begin
                rd_busy_r <= rd_busy_r;
            end
        end
    end

    sat_counter #(
        .W (OVR_W)
    ) u_ovr_cnt (
        .clk (lc_clk_c),
        .clr (rst),
        .inc (drop_s),
        .q   (overrun_cnt)
    );

    assign switch      = switch_r;
    assign lc_addra    = lc_addra_r;
    assign wr_en       = wr_en_r;
    assign dt_an       = dt_an_r;
    assign frame_ready = frame_ready_r;
    assign rd_busy     = rd_busy_r;
    assign state_o     = state_r;

endmodule

// File: tb/tb_pingpong_frame_ctrl.sv
// Self-checking bench for pingpong_frame_ctrl with a write/frame scoreboard.
module tb_pingpong_frame_ctrl;

    localparam int FL = 8;

    logic        lc_clk_c = 1'b0;
    logic        rst;
    logic        enable;
    logic        samp_valid;
    logic [31:0] samp_data;
    logic        rd_done;

    logic        switch;
    logic [11:0] lc_addra;
    logic        wr_en;
    logic [31:0] dt_an;
    logic        frame_ready;
    logic        rd_busy;
    logic [15:0] overrun_cnt;
    logic [1:0]  state_o;

    logic        sw_b;
    logic [11:0] addr_b;
    logic        wr_en_b;
    logic [31:0] dt_an_b;
    logic        fr_b;
    logic        busy_b;
    logic [2:0]  ovr_b;
    logic [1:0]  st_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  wr_q[$];
    logic fr_q[$];
    wr_t  mon_w;
    logic mon_s;

    always #5 lc_clk_c = ~lc_clk_c;

    pingpong_frame_ctrl #(.ADDR_W(12), .DATA_W(32), .FRAME_LEN(FL), .OVR_W(16)) dut (
        .lc_clk_c (lc_clk_c), .rst (rst), .enable (enable),
        .samp_valid (samp_valid), .samp_data (samp_data), .rd_done (rd_done),
        .switch (switch), .lc_addra (lc_addra), .wr_en (wr_en), .dt_an (dt_an),
        .frame_ready (frame_ready), .rd_busy (rd_busy),
        .overrun_cnt (overrun_cnt), .state_o (state_o)
    );

    pingpong_frame_ctrl #(.ADDR_W(12), .DATA_W(32), .FRAME_LEN(FL), .OVR_W(3)) dut_sat (
        .lc_clk_c (lc_clk_c), .rst (rst), .enable (enable),
        .samp_valid (samp_valid), .samp_data (samp_data), .rd_done (rd_done),
        .switch (sw_b), .lc_addra (addr_b), .wr_en (wr_en_b), .dt_an (dt_an_b),
        .frame_ready (fr_b), .rd_busy (busy_b),
        .overrun_cnt (ovr_b), .state_o (st_b)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge lc_clk_c);
        #1;
    endtask

    task automatic send_sample(input logic [31:0] d);
        samp_valid = 1'b1;
        samp_data  = d;
        step();
        samp_valid = 1'b0;
    endtask

    // Full frame at addresses 0..FL-1, one idle cycle after each sample.
    task automatic fill_frame(input logic [31:0] base);
        for (int i = 0; i < FL; i++) begin
            wr_q.push_back({12'(i), base + 32'(i)});
            send_sample(base + 32'(i));
            step();
        end
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_state"}, {30'd0, state_o}, 32'd0);
        check_val({tag, "_switch"}, {31'd0, switch}, 32'd0);
        check_val({tag, "_addr"}, {20'd0, lc_addra}, 32'd0);
        check_val({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check_val({tag, "_dt_an"}, dt_an, 32'd0);
        check_val({tag, "_fready"}, {31'd0, frame_ready}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, rd_busy}, 32'd0);
        check_val({tag, "_ovr"}, {16'd0, overrun_cnt}, 32'd0);
    endtask

    // Scoreboard: every write and every frame handover must be expected.
    always @(negedge lc_clk_c) begin
        if (wr_en) begin
            if (wr_q.size() == 0) begin
                check_val("wr_unexpected", 32'd1, 32'd0);
            end else begin
                mon_w = wr_q.pop_front();
                check_val("wr_addr", {20'd0, lc_addra}, {20'd0, mon_w.addr});
                check_val("wr_data", dt_an, mon_w.data);
            end
        end
        if (frame_ready) begin
            if (fr_q.size() == 0) begin
                check_val("fr_unexpected", 32'd1, 32'd0);
            end else begin
                mon_s = fr_q.pop_front();
                check_val("fr_switch", {31'd0, switch}, {31'd0, mon_s});
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; samp_valid = 1'b0; samp_data = 32'd0; rd_done = 1'b0;
        step();
        step();
        check_reset("rst0");
        rst = 1'b0;

        // Basic frame into bank m1, then handover.
        enable = 1'b1;
        step();
        check_val("p1_fill", {30'd0, state_o}, 32'd1);
        fill_frame(32'h100);
        check_val("p1_swap", {30'd0, state_o}, 32'd3);
        check_val("p1_sw_pre", {31'd0, switch}, 32'd0);
        fr_q.push_back(1'b1);
        step();
        check_val("p1_sw", {31'd0, switch}, 32'd1);
        check_val("p1_busy", {31'd0, rd_busy}, 32'd1);
        check_val("p1_state", {30'd0, state_o}, 32'd1);

        // Back-pressure: reader keeps the bank, extra samples dropped.
        fill_frame(32'h200);
        check_val("p2_full", {30'd0, state_o}, 32'd2);
        for (int i = 0; i < 5; i++) begin
            send_sample(32'h2F0 + 32'(i));
            step();
        end
        check_val("p2_ovr", {16'd0, overrun_cnt}, 32'd5);
        check_val("p2_ovr_b", {29'd0, ovr_b}, 32'd5);
        check_val("p2_hold", {30'd0, state_o}, 32'd2);
        check_val("p2_sw_hold", {31'd0, switch}, 32'd1);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check_val("p2_swap", {30'd0, state_o}, 32'd3);
        check_val("p2_busy_clr", {31'd0, rd_busy}, 32'd0);
        fr_q.push_back(1'b0);
        step();
        check_val("p2_sw", {31'd0, switch}, 32'd0);
        check_val("p2_busy", {31'd0, rd_busy}, 32'd1);
        check_val("p2_ovr_keep", {16'd0, overrun_cnt}, 32'd5);

        // rd_done held across FULL->SWAP and the SWAP cycle: set wins.
        fill_frame(32'h300);
        check_val("p3_full", {30'd0, state_o}, 32'd2);
        rd_done = 1'b1;
        step();
        check_val("p3_swap", {30'd0, state_o}, 32'd3);
        fr_q.push_back(1'b1);
        step();
        rd_done = 1'b0;
        check_val("p3_busy", {31'd0, rd_busy}, 32'd1);
        check_val("p3_sw", {31'd0, switch}, 32'd1);
        check_val("p3_state", {30'd0, state_o}, 32'd1);

        // Abort after 3 samples, then restart at address 0.
        for (int i = 0; i < 3; i++) begin
            wr_q.push_back({12'(i), 32'h400 + 32'(i)});
            send_sample(32'h400 + 32'(i));
            step();
        end
        enable = 1'b0;
        step();
        check_val("p4_idle", {30'd0, state_o}, 32'd0);
        check_val("p4_sw", {31'd0, switch}, 32'd1);
        check_val("p4_busy", {31'd0, rd_busy}, 32'd1);
        enable = 1'b1;
        step();
        check_val("p4_fill", {30'd0, state_o}, 32'd1);
        wr_q.push_back({12'd0, 32'h500});
        send_sample(32'h500);
        step();

        // Reset while in FULL with three dropped samples.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_val("p5_fill", {30'd0, state_o}, 32'd1);
        fill_frame(32'h600);
        fr_q.push_back(1'b1);
        step();
        fill_frame(32'h700);
        check_val("p5_full", {30'd0, state_o}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            send_sample(32'h7F0 + 32'(i));
            step();
        end
        check_val("p5_ovr", {16'd0, overrun_cnt}, 32'd3);
        rst = 1'b1;
        enable = 1'b0;
        step();
        check_reset("p5_rst");
        rst = 1'b0;

        // Saturation of the narrow overrun counter.
        enable = 1'b1;
        step();
        fill_frame(32'h800);
        fr_q.push_back(1'b1);
        step();
        fill_frame(32'h900);
        check_val("p6_full", {30'd0, state_o}, 32'd2);
        for (int i = 0; i < 10; i++) begin
            send_sample(32'h9F0 + 32'(i));
            step();
        end
        check_val("p6_ovr16", {16'd0, overrun_cnt}, 32'd10);
        check_val("p6_ovr3", {29'd0, ovr_b}, 32'd7);

        step();
        check_val("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check_val("fr_q_empty", 32'(fr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
